// File: rtl/regwr_pkg.sv
// Shared types and defaults for the register-file write arbiter.
// The REGWR_STATS_EN build adds conflict/drop counters at the top level.
package regwr_pkg;

  localparam int DATA_WIDTH_DEF = 64;
  localparam int ADDR_WIDTH_DEF = 5;
  localparam int ZERO_REG       = 31;

  typedef enum logic {
    PRI0 = 1'b0,
    PRI1 = 1'b1
  } rr_state_t;

  typedef struct packed {
    logic [ADDR_WIDTH_DEF-1:0] addr;
    logic [DATA_WIDTH_DEF-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter with stall gating.
// Reset and stall both force an idle grant vector.
module rr_arbiter_2
  import regwr_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       stall_i,
  input  logic       valid0_i,
  input  logic       valid1_i,
  output logic [1:0] gnt_o
);

  rr_state_t state_q, state_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= PRI0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    gnt_o   = 2'b00;
    state_d = state_q;
    if (!reset_i && !stall_i) begin
      unique case ({valid1_i, valid0_i})
        2'b11: gnt_o = (state_q == PRI0) ? 2'b01 : 2'b10;
        2'b01: gnt_o = 2'b01;
        2'b10: gnt_o = 2'b10;
        default: gnt_o = 2'b00;
      endcase
    end
    if (gnt_o[0]) begin
      state_d = PRI1;
    end else if (gnt_o[1]) begin
      state_d = PRI0;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between ALU and load writeback.
// Define REGWR_STATS_EN to add conflict_count and drop_count outputs.
module regfile_write_arbiter
  import regwr_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  output logic [NUM_REGS-1:0]   wr_en,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [ADDR_WIDTH-1:0] wr_addr
`ifdef REGWR_STATS_EN
  ,
  output logic [15:0]           conflict_count,
  output logic [15:0]           drop_count
`endif
);

  logic [1:0]            gnt;
  logic                  xfer;
  wr_req_t               sel;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  logic [NUM_REGS-1:0]   wr_en_q, wr_en_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;

  rr_arbiter_2 u_arb (
    .clk_i    (clk),
    .reset_i  (reset),
    .stall_i  (stall),
    .valid0_i (req0_valid),
    .valid1_i (req1_valid),
    .gnt_o    (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign xfer       = |gnt;

  always_comb begin
    sel.addr = ADDR_WIDTH_DEF'(req0_addr);
    sel.data = DATA_WIDTH_DEF'(req0_data);
    if (gnt[1]) begin
      sel.addr = ADDR_WIDTH_DEF'(req1_addr);
      sel.data = DATA_WIDTH_DEF'(req1_data);
    end
  end

  assign sel_addr = ADDR_WIDTH'(sel.addr);
  assign sel_data = DATA_WIDTH'(sel.data);

  // Zero register and anything above it never enable a register.
  always_comb begin
    wr_en_d   = '0;
    wr_data_d = wr_data_q;
    wr_addr_d = wr_addr_q;
    if (xfer) begin
      wr_data_d = sel_data;
      wr_addr_d = sel_addr;
      if (32'(sel_addr) < 32'(NUM_REGS - 1)) begin
        wr_en_d[sel_addr] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en_q   <= '0;
      wr_data_q <= '0;
      wr_addr_q <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_data = wr_data_q;
  assign wr_addr = wr_addr_q;

`ifdef REGWR_STATS_EN
  logic [15:0] conf_q, conf_d;
  logic [15:0] drop_q, drop_d;
  logic        is_zero;

  assign is_zero = (32'(sel_addr) == 32'(NUM_REGS - 1));

  always_comb begin
    conf_d = conf_q;
    drop_d = drop_q;
    if (xfer && req0_valid && req1_valid && conf_q != 16'hFFFF) begin
      conf_d = conf_q + 16'd1;
    end
    if (xfer && is_zero && drop_q != 16'hFFFF) begin
      drop_d = drop_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      conf_q <= '0;
      drop_q <= '0;
    end else begin
      conf_q <= conf_d;
      drop_q <= drop_d;
    end
  end

  assign conflict_count = conf_q;
  assign drop_count     = drop_q;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Table-driven directed cases plus randomized model checking.
// Also checks counters when built with REGWR_STATS_EN.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset, stall;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_addr, req1_addr;
  logic [63:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic [31:0] wr_en;
  logic [63:0] wr_data;
  logic [4:0]  wr_addr;
`ifdef REGWR_STATS_EN
  logic [15:0] conflict_count, drop_count;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_addr    (wr_addr)
`ifdef REGWR_STATS_EN
    ,
    .conflict_count (conflict_count),
    .drop_count     (drop_count)
`endif
  );

  typedef struct {
    logic        rst, st, v0, v1;
    logic [4:0]  a0, a1;
    logic [63:0] d0, d1;
    logic        r0, r1;
    logic [31:0] en;
    logic [63:0] data;
    logic [4:0]  addr;
  } vec_t;

  vec_t tbl[$];

  logic        g_r0, g_r1;
  logic [31:0] g_en;
  logic [63:0] g_data;
  logic [4:0]  g_addr;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic add(input logic rst, st, v0, input logic [4:0] a0,
                     input logic [63:0] d0, input logic v1,
                     input logic [4:0] a1, input logic [63:0] d1,
                     input logic r0, r1, input logic [31:0] en,
                     input logic [63:0] data, input logic [4:0] addr);
    vec_t v;
    v.rst = rst; v.st = st; v.v0 = v0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.a1 = a1; v.d1 = d1; v.r0 = r0; v.r1 = r1;
    v.en = en; v.data = data; v.addr = addr;
    tbl.push_back(v);
  endtask

  task automatic step(input vec_t v);
    reset = v.rst; stall = v.st;
    req0_valid = v.v0; req0_addr = v.a0; req0_data = v.d0;
    req1_valid = v.v1; req1_addr = v.a1; req1_data = v.d1;
    #1;
    g_r0 = req0_ready; g_r1 = req1_ready;
    @(posedge clk);
    #1;
    g_en = wr_en; g_data = wr_data; g_addr = wr_addr;
  endtask

  int          pref, w;
  logic [31:0] m_en;
  logic [63:0] m_data;
  logic [4:0]  m_addr;
  int          m_conf, m_drop;

  initial begin
    vec_t v;
    logic [4:0] a;
    // rst st v0 a0 d0 v1 a1 d1 | r0 r1 en data addr
    add(1,0,1,3,64'hAA,1,4,64'hBB, 0,0,32'h0,64'h0,0);
    add(1,0,1,3,64'hAA,1,4,64'hBB, 0,0,32'h0,64'h0,0);
    add(0,0,1,3,64'hAA,1,4,64'hBB, 1,0,32'h8,64'hAA,3);
    add(0,0,0,3,64'hAA,1,4,64'hBB, 0,1,32'h10,64'hBB,4);
    add(0,0,1,5,64'hDEAD_BEEF,0,0,0, 1,0,32'h20,64'hDEAD_BEEF,5);
    add(0,0,0,0,0,0,0,0, 0,0,32'h0,64'hDEAD_BEEF,5);
    add(0,0,0,0,0,1,9,64'h99, 0,1,32'h200,64'h99,9);
    add(0,0,1,1,64'h11,1,2,64'h22, 1,0,32'h2,64'h11,1);
    add(0,0,1,1,64'h11,1,2,64'h22, 0,1,32'h4,64'h22,2);
    add(0,0,1,1,64'h11,1,2,64'h22, 1,0,32'h2,64'h11,1);
    add(0,0,1,1,64'h11,1,2,64'h22, 0,1,32'h4,64'h22,2);
    add(0,0,1,1,64'h11,1,2,64'h22, 1,0,32'h2,64'h11,1);
    add(0,1,1,1,64'h11,1,2,64'h22, 0,0,32'h0,64'h11,1);
    add(0,1,1,1,64'h11,1,2,64'h22, 0,0,32'h0,64'h11,1);
    add(0,1,1,1,64'h11,1,2,64'h22, 0,0,32'h0,64'h11,1);
    add(0,0,1,1,64'h11,1,2,64'h22, 0,1,32'h4,64'h22,2);
    add(0,0,0,0,0,1,31,64'h1, 0,1,32'h0,64'h1,31);
    add(0,0,1,6,64'h66,0,0,0, 1,0,32'h40,64'h66,6);
    add(1,0,1,7,64'h77,0,0,0, 0,0,32'h0,64'h0,0);
    add(0,0,1,1,64'h11,1,2,64'h22, 1,0,32'h2,64'h11,1);
    add(0,0,0,0,0,0,0,0, 0,0,32'h0,64'h11,1);

    foreach (tbl[i]) begin
      step(tbl[i]);
      chk($sformatf("t%0d_r0", i), 64'(g_r0), 64'(tbl[i].r0));
      chk($sformatf("t%0d_r1", i), 64'(g_r1), 64'(tbl[i].r1));
      chk($sformatf("t%0d_en", i), 64'(g_en), 64'(tbl[i].en));
      chk($sformatf("t%0d_data", i), g_data, tbl[i].data);
      chk($sformatf("t%0d_addr", i), 64'(g_addr), 64'(tbl[i].addr));
    end

    pref = 0; m_en = 0; m_data = 0; m_addr = 0;
    m_conf = 0; m_drop = 0;
    v = tbl[0];
    v.v0 = 0; v.v1 = 0;
    for (int c = 0; c < 600; c++) begin
      v.rst = (c == 0) || ($urandom_range(0, 49) == 0);
      v.st  = ($urandom_range(0, 5) == 0);
      if (!(v.v0 && g_r0 == 1'b0 && !v.rst && c > 0)) begin
        v.v0 = $urandom_range(0, 2) != 0;
        v.a0 = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom);
        v.d0 = {$urandom, $urandom};
      end
      if (!(v.v1 && g_r1 == 1'b0 && !v.rst && c > 0)) begin
        v.v1 = $urandom_range(0, 2) != 0;
        v.a1 = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom);
        v.d1 = {$urandom, $urandom};
      end
      w = -1;
      if (!v.rst && !v.st) begin
        if (v.v0 && v.v1) w = pref;
        else if (v.v0) w = 0;
        else if (v.v1) w = 1;
      end
      step(v);
      if (v.rst) begin
        pref = 0; m_en = 0; m_data = 0; m_addr = 0;
        m_conf = 0; m_drop = 0;
      end else if (w >= 0) begin
        a = (w == 1) ? v.a1 : v.a0;
        m_data = (w == 1) ? v.d1 : v.d0;
        m_addr = a;
        m_en = (a < 5'd31) ? (32'h1 << a) : 32'h0;
        if (v.v0 && v.v1 && m_conf < 65535) m_conf++;
        if (a == 5'd31 && m_drop < 65535) m_drop++;
        pref = 1 - w;
      end else begin
        m_en = 0;
      end
      chk($sformatf("r%0d_r0", c), 64'(g_r0), 64'(w == 0));
      chk($sformatf("r%0d_r1", c), 64'(g_r1), 64'(w == 1));
      chk($sformatf("r%0d_en", c), 64'(g_en), 64'(m_en));
      chk($sformatf("r%0d_data", c), g_data, m_data);
      chk($sformatf("r%0d_addr", c), 64'(g_addr), 64'(m_addr));
`ifdef REGWR_STATS_EN
      chk($sformatf("r%0d_conf", c), 64'(conflict_count), 64'(m_conf));
      chk($sformatf("r%0d_drop", c), 64'(drop_count), 64'(m_drop));
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
